// File: rtl/int2fp_rr_scheduler.sv
// Generic synchronous FIFO, first-word fall-through, head data forced to zero when empty.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: none internally; the writer must never push while full.
module int2fp_rr_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             full;

    assign head_vld = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = head_vld & pop_rdy;
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assert property (@(posedge clk) disable iff (!rstn) !(push_vld && full));
endmodule

// Round-robin share of one fixed-latency int->fp32 converter among NUM_REQ requesters.
// Latency: grant to result visible at out_valid is CONV_LATENCY+2 cycles when the FIFO is empty.
// Backpressure: credits (FIFO occupancy + in-flight) gate grants; the converter itself never stalls.
module int2fp_rr_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int DATA_W       = 16,
    parameter int CONV_LATENCY = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      conv_values_rdy,
    output logic                      conv_sign,
    output logic [DATA_W-1:0]         conv_quantized_d,
    input  logic                      conv_result_rdy,
    input  logic [31:0]               conv_quantized_fp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      err_sticky
);
    localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int              WU_W    = $clog2(CONV_LATENCY + 1);
    localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W:0]  CREDITS = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [WU_W-1:0] WU_LOAD = WU_W'(CONV_LATENCY);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     fp;
    } entry_t;

    logic [ID_W-1:0]         rr_ptr;
    logic [WU_W-1:0]         warm_cnt;
    logic                    warmup;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic                    issue_ok;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic [DATA_W-1:0]       sel_dat;
    logic [DATA_W-1:0]       sel_mag;
    // Stage 0 is loaded alongside the issue register, so the last stage lines up with the result strobe.
    tag_t [CONV_LATENCY:0]   tag_pipe;
    tag_t                    tag_last;
    logic                    res_push;
    logic                    res_err;
    entry_t                  push_dat;
    entry_t                  head_dat;

    assign warmup   = (warm_cnt != '0);
    assign issue_ok = !warmup && (({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS);

    always_comb begin : arb
        logic [ID_W:0] cand;
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (issue_ok) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (cand >= NREQ) cand = cand - NREQ;
                if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_id  = cand[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = grant_vld;
    end

    assign sel_dat = req_data[grant_id*DATA_W +: DATA_W];
    // Two's-complement negate; the most negative value maps onto its unsigned magnitude.
    assign sel_mag = sel_dat[DATA_W-1] ? (~sel_dat + DATA_W'(1)) : sel_dat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr           <= '0;
            warm_cnt         <= WU_LOAD;
            conv_values_rdy  <= 1'b0;
            conv_sign        <= 1'b0;
            conv_quantized_d <= '0;
        end else begin
            if (warmup) warm_cnt <= warm_cnt - 1'b1;
            if (grant_vld) rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            conv_values_rdy <= grant_vld;
            if (grant_vld) begin
                conv_sign        <= sel_dat[DATA_W-1];
                conv_quantized_d <= sel_mag;
            end
        end
    end

    assign tag_last = tag_pipe[CONV_LATENCY];
    assign res_push = !warmup && tag_last.vld && conv_result_rdy;
    assign res_err  = !warmup && (tag_last.vld ^ conv_result_rdy);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_pipe   <= '0;
            inflight   <= '0;
            err_sticky <= 1'b0;
        end else begin
            tag_pipe <= {tag_pipe[CONV_LATENCY-1:0], tag_t'({grant_vld, grant_id})};
            case ({grant_vld, tag_last.vld})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (res_err) err_sticky <= 1'b1;
        end
    end

    assign push_dat = '{id: tag_last.id, fp: conv_quantized_fp};

    int2fp_rr_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push_vld (res_push),
        .push_dat (push_dat),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign out_data = head_dat.fp;
    assign out_id   = head_dat.id;
endmodule
